// File: rtl/cache_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_if
// Brief    : Bus bundle for cache_ctrl: CPU request/response channel, cache
//            array port and handshaked backing-memory port.
//            master = controller side, slave = environment side
//            (CPU, cache array and memory).
// Revision : 1.0 - initial release
// ============================================================================
interface cache_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // CPU channel
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // Cache array port
    logic [ADDR_W-1:0] c_addr;
    logic              c_write;
    logic [DATA_W-1:0] c_data_in;
    logic [DATA_W-1:0] c_found;
    logic              c_hit;

    // Backing memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata,
        output c_addr, c_write, c_data_in,
        input  c_found, c_hit,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata,
        input  c_addr, c_write, c_data_in,
        output c_found, c_hit,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl
// Brief    : Single-outstanding sequencer between a CPU, a cache array and a
//            handshaked backing memory. Reads look up the cache and fill on a
//            miss; writes are write-through with write-allocate. Saturating
//            read hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module cache_ctrl #(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int LOOKUP_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    cache_ctrl_if.master bus,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MEM_RD = 3'd2,
        S_FILL   = 3'd3,
        S_MEM_WR = 3'd4,
        S_RESP   = 3'd5
    } state_t;

    // Lookup counter value on the cycle whose closing edge samples c_hit.
    localparam logic [2:0]  LK_LAST = 3'(LOOKUP_CYCLES - 1);
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    // Lookup counter is 3 bits wide, so the legal range is 1..7.
    if (LOOKUP_CYCLES < 1 || LOOKUP_CYCLES > 7) begin : g_bad_lookup_cycles
        $error("cache_ctrl: LOOKUP_CYCLES must be in 1..7");
    end

    state_t            state_q,      state_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic              we_q,         we_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic [DATA_W-1:0] data_q,       data_d;
    logic [2:0]        lk_cnt_q,     lk_cnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [ADDR_W-1:0] c_addr_q,     c_addr_d;
    logic              c_write_q,    c_write_d;
    logic [DATA_W-1:0] c_data_in_q,  c_data_in_d;
    logic              mem_req_q,    mem_req_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic [15:0]       hit_cnt_q,    hit_cnt_d;
    logic [15:0]       miss_cnt_q,   miss_cnt_d;

    // Next-state and next-output logic; every output is computed one cycle
    // ahead so that it appears registered in the state it belongs to.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        data_d       = data_q;
        lk_cnt_d     = lk_cnt_q;
        cpu_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        c_addr_d     = c_addr_q;
        c_write_d    = 1'b0;
        c_data_in_d  = c_data_in_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    we_d    = bus.cpu_we;
                    wdata_d = bus.cpu_wdata;
                    if (bus.cpu_we) begin
                        // Write-allocate: update the cache first, then memory.
                        state_d     = S_FILL;
                        data_d      = bus.cpu_wdata;
                        c_addr_d    = bus.cpu_addr;
                        c_write_d   = 1'b1;
                        c_data_in_d = bus.cpu_wdata;
                    end else begin
                        state_d  = S_LOOKUP;
                        c_addr_d = bus.cpu_addr;
                        lk_cnt_d = 3'd0;
                    end
                end
            end

            S_LOOKUP: begin
                if (lk_cnt_q == LK_LAST) begin
                    if (bus.c_hit) begin
                        state_d      = S_RESP;
                        data_d       = bus.c_found;
                        cpu_rvalid_d = 1'b1;
                        cpu_rdata_d  = bus.c_found;
                        if (hit_cnt_q != CNT_MAX) begin
                            hit_cnt_d = hit_cnt_q + 16'd1;
                        end
                    end else begin
                        // c_found carries the miss sentinel here; drop it.
                        state_d    = S_MEM_RD;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = addr_q;
                        if (miss_cnt_q != CNT_MAX) begin
                            miss_cnt_d = miss_cnt_q + 16'd1;
                        end
                    end
                end else begin
                    lk_cnt_d = lk_cnt_q + 3'd1;
                end
            end

            S_MEM_RD: begin
                if (bus.mem_ack) begin
                    state_d     = S_FILL;
                    mem_req_d   = 1'b0;
                    data_d      = bus.mem_rdata;
                    c_addr_d    = addr_q;
                    c_write_d   = 1'b1;
                    c_data_in_d = bus.mem_rdata;
                end
            end

            S_FILL: begin
                if (we_q) begin
                    state_d     = S_MEM_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                end else begin
                    state_d      = S_RESP;
                    cpu_rvalid_d = 1'b1;
                    cpu_rdata_d  = data_q;
                end
            end

            S_MEM_WR: begin
                if (bus.mem_ack) begin
                    state_d      = S_RESP;
                    mem_req_d    = 1'b0;
                    cpu_rvalid_d = 1'b1;
                    cpu_rdata_d  = wdata_q;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset also aborts
    // any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            data_q       <= '0;
            lk_cnt_q     <= 3'd0;
            cpu_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            c_addr_q     <= '0;
            c_write_q    <= 1'b0;
            c_data_in_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_cnt_q    <= 16'd0;
            miss_cnt_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            data_q       <= data_d;
            lk_cnt_q     <= lk_cnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            c_addr_q     <= c_addr_d;
            c_write_q    <= c_write_d;
            c_data_in_q  <= c_data_in_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign bus.cpu_ready  = (state_q == S_IDLE);
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.c_addr     = c_addr_q;
    assign bus.c_write    = c_write_q;
    assign bus.c_data_in  = c_data_in_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign hit_cnt        = hit_cnt_q;
    assign miss_cnt       = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ctrl
// Brief    : Directed self-checking bench for cache_ctrl with a behavioural
//            cache array (negedge) and a delayed-ack memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
    int          checks;
    int          failures;

    cache_ctrl_if bus_if ();

    cache_ctrl #(.ADDR_W(16), .DATA_W(16), .LOOKUP_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural cache array: direct-mapped on addr[7:0], samples on negedge.
    logic [15:0] cm_data  [256];
    logic [15:0] cm_tag   [256];
    logic        cm_valid [256];
    initial begin
        for (int i = 0; i < 256; i++) cm_valid[i] = 1'b0;
        bus_if.c_hit   = 1'b0;
        bus_if.c_found = 16'hFFF0;
        forever begin
            @(negedge clk);
            if (cm_valid[bus_if.c_addr[7:0]] && cm_tag[bus_if.c_addr[7:0]] == bus_if.c_addr) begin
                bus_if.c_hit   = 1'b1;
                bus_if.c_found = cm_data[bus_if.c_addr[7:0]];
            end else begin
                bus_if.c_hit   = 1'b0;
                bus_if.c_found = 16'hFFF0;
            end
            if (bus_if.c_write) begin
                cm_valid[bus_if.c_addr[7:0]] = 1'b1;
                cm_tag[bus_if.c_addr[7:0]]   = bus_if.c_addr;
                cm_data[bus_if.c_addr[7:0]]  = bus_if.c_data_in;
            end
        end
    end

    // Memory responder: acks after ack_delay waiting cycles of mem_req.
    int          ack_delay;
    logic [15:0] mem_value;
    initial begin
        int mem_wait;
        mem_wait         = 0;
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (bus_if.mem_ack) begin
                bus_if.mem_ack = 1'b0;
                mem_wait       = 0;
            end else if (bus_if.mem_req) begin
                if (mem_wait >= ack_delay) begin
                    bus_if.mem_ack   = 1'b1;
                    bus_if.mem_rdata = mem_value;
                end else begin
                    mem_wait++;
                end
            end else begin
                mem_wait = 0;
            end
        end
    end

    // Bus monitor: counts activity at negedge, when everything is stable.
    int          n_memreq, n_fill, n_rvalid, n_accept, n_unstable;
    logic [15:0] last_mem_addr, last_mem_wdata, last_fill_addr, last_fill_data;
    logic        last_mem_we;
    initial begin
        logic        prev_req;
        logic [15:0] prev_addr, prev_wdata;
        logic        prev_we;
        n_memreq = 0; n_fill = 0; n_rvalid = 0; n_accept = 0; n_unstable = 0;
        prev_req = 1'b0; prev_addr = '0; prev_wdata = '0; prev_we = 1'b0;
        last_mem_addr = '0; last_mem_wdata = '0; last_mem_we = 1'b0;
        last_fill_addr = '0; last_fill_data = '0;
        forever begin
            @(negedge clk);
            if (bus_if.mem_req === 1'b1) begin
                n_memreq++;
                last_mem_addr  = bus_if.mem_addr;
                last_mem_we    = bus_if.mem_we;
                last_mem_wdata = bus_if.mem_wdata;
                if (prev_req && (prev_addr != bus_if.mem_addr || prev_we != bus_if.mem_we ||
                                 prev_wdata != bus_if.mem_wdata))
                    n_unstable++;
            end
            prev_req   = (bus_if.mem_req === 1'b1);
            prev_addr  = bus_if.mem_addr;
            prev_we    = bus_if.mem_we;
            prev_wdata = bus_if.mem_wdata;
            if (bus_if.c_write === 1'b1) begin
                n_fill++;
                last_fill_addr = bus_if.c_addr;
                last_fill_data = bus_if.c_data_in;
            end
            if (bus_if.cpu_rvalid === 1'b1) n_rvalid++;
            if (!rst && bus_if.cpu_req && bus_if.cpu_ready === 1'b1) n_accept++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one accepting edge (controller is idle).
    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        bus_if.cpu_req   = 1'b1;
        bus_if.cpu_we    = we;
        bus_if.cpu_addr  = addr;
        bus_if.cpu_wdata = wdata;
        step();
        bus_if.cpu_req   = 1'b0;
    endtask

    // Steps until cpu_rvalid is seen; cycles counts edges after the accept edge.
    task automatic wait_rvalid(input int max_cycles, output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < max_cycles && !ok) begin
            step();
            cycles++;
            if (bus_if.cpu_rvalid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus_if.cpu_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", bus_if.cpu_ready); end
        checks++; if (bus_if.cpu_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid: got %b want 0", bus_if.cpu_rvalid); end
        checks++; if (bus_if.cpu_rdata !== 16'h0000) begin failures++; $display("FAIL rst_rdata: got %h want 0000", bus_if.cpu_rdata); end
        checks++; if ({bus_if.c_write, bus_if.c_addr, bus_if.c_data_in} !== 33'd0) begin failures++; $display("FAIL rst_cache_port: got %b/%h/%h want 0/0000/0000", bus_if.c_write, bus_if.c_addr, bus_if.c_data_in); end
        checks++; if ({bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata} !== 34'd0) begin failures++; $display("FAIL rst_mem_port: got %b/%b/%h/%h want all 0", bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata); end
        checks++; if ({hit_cnt, miss_cnt} !== 32'd0) begin failures++; $display("FAIL rst_counters: got %h/%h want 0000/0000", hit_cnt, miss_cnt); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_read_miss();
        int cyc; bit ok; int r0, f0, v0;
        ack_delay = 3; mem_value = 16'hBEEF;
        r0 = n_memreq; f0 = n_fill; v0 = n_rvalid;
        issue(1'b0, 16'h0010, 16'h0000);
        checks++; if (bus_if.cpu_ready !== 1'b0 || bus_if.c_addr !== 16'h0010 || bus_if.c_write !== 1'b0) begin failures++; $display("FAIL miss_lookup_bus: got ready=%b addr=%h wr=%b want 0/0010/0", bus_if.cpu_ready, bus_if.c_addr, bus_if.c_write); end
        wait_rvalid(20, cyc, ok);
        checks++; if (!ok || cyc != 7) begin failures++; $display("FAIL miss_latency: got ok=%0d cycles=%0d want 1/7", ok, cyc); end
        checks++; if (bus_if.cpu_rdata !== 16'hBEEF) begin failures++; $display("FAIL miss_rdata: got %h want beef", bus_if.cpu_rdata); end
        checks++; if (n_memreq - r0 != 4 || last_mem_addr !== 16'h0010 || last_mem_we !== 1'b0) begin failures++; $display("FAIL miss_mem_req: got cycles=%0d addr=%h we=%b want 4/0010/0", n_memreq - r0, last_mem_addr, last_mem_we); end
        checks++; if (n_fill - f0 != 1 || last_fill_data !== 16'hBEEF || last_fill_addr !== 16'h0010) begin failures++; $display("FAIL miss_fill: got n=%0d addr=%h data=%h want 1/0010/beef", n_fill - f0, last_fill_addr, last_fill_data); end
        step();
        checks++; if (bus_if.cpu_rvalid !== 1'b0 || bus_if.cpu_ready !== 1'b1 || n_rvalid - v0 != 1) begin failures++; $display("FAIL miss_rvalid_pulse: got rvalid=%b ready=%b pulses=%0d want 0/1/1", bus_if.cpu_rvalid, bus_if.cpu_ready, n_rvalid - v0); end
        checks++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd0) begin failures++; $display("FAIL miss_counters: got hit=%h miss=%h want 0000/0001", hit_cnt, miss_cnt); end
    endtask

    task automatic test_read_hit();
        int cyc; bit ok; int r0, f0;
        r0 = n_memreq; f0 = n_fill;
        issue(1'b0, 16'h0010, 16'h0000);
        wait_rvalid(20, cyc, ok);
        checks++; if (!ok || cyc != 2) begin failures++; $display("FAIL hit_latency: got ok=%0d cycles=%0d want 1/2", ok, cyc); end
        checks++; if (bus_if.cpu_rdata !== 16'hBEEF) begin failures++; $display("FAIL hit_rdata: got %h want beef", bus_if.cpu_rdata); end
        checks++; if (bus_if.cpu_ready !== 1'b0) begin failures++; $display("FAIL hit_ready_in_resp: got %b want 0", bus_if.cpu_ready); end
        step();
        checks++; if (bus_if.cpu_ready !== 1'b1 || bus_if.cpu_rvalid !== 1'b0) begin failures++; $display("FAIL hit_return_idle: got ready=%b rvalid=%b want 1/0", bus_if.cpu_ready, bus_if.cpu_rvalid); end
        checks++; if (n_memreq != r0 || n_fill != f0) begin failures++; $display("FAIL hit_no_traffic: got memreq=%0d fills=%0d want 0/0", n_memreq - r0, n_fill - f0); end
        checks++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin failures++; $display("FAIL hit_counters: got hit=%h miss=%h want 0001/0001", hit_cnt, miss_cnt); end
    endtask

    task automatic test_write_allocate();
        int cyc; bit ok; int r0, f0, u0;
        ack_delay = 2; mem_value = 16'hDEAD;
        r0 = n_memreq; f0 = n_fill; u0 = n_unstable;
        issue(1'b1, 16'h0020, 16'h1234);
        checks++; if (bus_if.c_write !== 1'b1 || bus_if.c_addr !== 16'h0020 || bus_if.c_data_in !== 16'h1234) begin failures++; $display("FAIL wr_fill: got wr=%b addr=%h data=%h want 1/0020/1234", bus_if.c_write, bus_if.c_addr, bus_if.c_data_in); end
        wait_rvalid(20, cyc, ok);
        checks++; if (!ok || cyc != 4) begin failures++; $display("FAIL wr_latency: got ok=%0d cycles=%0d want 1/4", ok, cyc); end
        checks++; if (bus_if.cpu_rdata !== 16'h1234) begin failures++; $display("FAIL wr_rdata: got %h want 1234", bus_if.cpu_rdata); end
        checks++; if (n_memreq - r0 != 3 || last_mem_we !== 1'b1 || last_mem_addr !== 16'h0020 || last_mem_wdata !== 16'h1234) begin failures++; $display("FAIL wr_mem: got cycles=%0d we=%b addr=%h data=%h want 3/1/0020/1234", n_memreq - r0, last_mem_we, last_mem_addr, last_mem_wdata); end
        checks++; if (n_unstable != u0 || n_fill - f0 != 1) begin failures++; $display("FAIL wr_stability: got unstable=%0d fills=%0d want 0/1", n_unstable - u0, n_fill - f0); end
        step();
        checks++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin failures++; $display("FAIL wr_counters: got hit=%h miss=%h want 0001/0001", hit_cnt, miss_cnt); end
        r0 = n_memreq;
        issue(1'b0, 16'h0020, 16'h0000);
        wait_rvalid(20, cyc, ok);
        checks++; if (!ok || cyc != 2 || bus_if.cpu_rdata !== 16'h1234) begin failures++; $display("FAIL wr_readback: got ok=%0d cycles=%0d data=%h want 1/2/1234", ok, cyc, bus_if.cpu_rdata); end
        step();
        checks++; if (n_memreq != r0 || hit_cnt !== 16'd2) begin failures++; $display("FAIL wr_readback_hit: got memreq=%0d hit=%h want 0/0002", n_memreq - r0, hit_cnt); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit ok; int r0, a0;
        ack_delay = 0; mem_value = 16'h5A5A;
        r0 = n_memreq; a0 = n_accept;
        bus_if.cpu_req   = 1'b1;
        bus_if.cpu_we    = 1'b0;
        bus_if.cpu_addr  = 16'h0030;
        bus_if.cpu_wdata = 16'h0000;
        step();
        // Second request presented immediately and held until taken.
        bus_if.cpu_addr = 16'h0010;
        wait_rvalid(20, cyc, ok);
        checks++; if (!ok || cyc != 4 || bus_if.cpu_rdata !== 16'h5A5A) begin failures++; $display("FAIL b2b_first: got ok=%0d cycles=%0d data=%h want 1/4/5a5a", ok, cyc, bus_if.cpu_rdata); end
        checks++; if (n_memreq - r0 != 1) begin failures++; $display("FAIL b2b_zero_wait_req: got %0d cycles want 1", n_memreq - r0); end
        step();
        checks++; if (bus_if.cpu_ready !== 1'b1 || n_accept - a0 != 1) begin failures++; $display("FAIL b2b_hold: got ready=%b accepts=%0d want 1/1", bus_if.cpu_ready, n_accept - a0); end
        step();
        bus_if.cpu_req = 1'b0;
        wait_rvalid(20, cyc, ok);
        checks++; if (!ok || cyc != 2 || bus_if.cpu_rdata !== 16'hBEEF) begin failures++; $display("FAIL b2b_second: got ok=%0d cycles=%0d data=%h want 1/2/beef", ok, cyc, bus_if.cpu_rdata); end
        step();
        checks++; if (n_accept - a0 != 2) begin failures++; $display("FAIL b2b_accepts: got %0d want 2", n_accept - a0); end
        checks++; if (hit_cnt !== 16'd3 || miss_cnt !== 16'd2) begin failures++; $display("FAIL b2b_counters: got hit=%h miss=%h want 0003/0002", hit_cnt, miss_cnt); end
    endtask

    task automatic test_reset_mid_txn();
        int n; int f0, v0;
        ack_delay = 10; mem_value = 16'h7777;
        f0 = n_fill; v0 = n_rvalid;
        issue(1'b0, 16'h0040, 16'h0000);
        n = 0;
        while (bus_if.mem_req !== 1'b1 && n < 10) begin step(); n++; end
        checks++; if (bus_if.mem_req !== 1'b1 || n != 2) begin failures++; $display("FAIL rstmid_reach_memrd: got req=%b cycles=%0d want 1/2", bus_if.mem_req, n); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus_if.mem_req !== 1'b0 || bus_if.cpu_ready !== 1'b1) begin failures++; $display("FAIL rstmid_state: got req=%b ready=%b want 0/1", bus_if.mem_req, bus_if.cpu_ready); end
        checks++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || bus_if.mem_addr !== 16'h0000) begin failures++; $display("FAIL rstmid_values: got hit=%h miss=%h maddr=%h want 0000/0000/0000", hit_cnt, miss_cnt, bus_if.mem_addr); end
        repeat (4) step();
        checks++; if (n_rvalid != v0 || n_fill != f0 || bus_if.mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_aborted: got rvalid=%0d fills=%0d req=%b want 0/0/0", n_rvalid - v0, n_fill - f0, bus_if.mem_req); end
    endtask

    task automatic test_miss_saturation();
        int cyc; bit ok;
        ack_delay = 0; mem_value = 16'h0A0A;
        // Stand-in for 0xFFFE prior misses.
        dut.miss_cnt_q = 16'hFFFE;
        issue(1'b0, 16'h0050, 16'h0000);
        wait_rvalid(20, cyc, ok);
        step();
        checks++; if (!ok || miss_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach_max: got ok=%0d miss=%h want 1/ffff", ok, miss_cnt); end
        issue(1'b0, 16'h0060, 16'h0000);
        wait_rvalid(20, cyc, ok);
        checks++; if (!ok || bus_if.cpu_rdata !== 16'h0A0A) begin failures++; $display("FAIL sat_rdata: got ok=%0d data=%h want 1/0a0a", ok, bus_if.cpu_rdata); end
        step();
        checks++; if (miss_cnt !== 16'hFFFF || hit_cnt !== 16'd0) begin failures++; $display("FAIL sat_hold: got miss=%h hit=%h want ffff/0000", miss_cnt, hit_cnt); end
        issue(1'b0, 16'h0050, 16'h0000);
        wait_rvalid(20, cyc, ok);
        step();
        checks++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hit_after: got hit=%h miss=%h want 0001/ffff", hit_cnt, miss_cnt); end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        ack_delay        = 0;
        mem_value        = 16'h0000;
        bus_if.cpu_req   = 1'b0;
        bus_if.cpu_we    = 1'b0;
        bus_if.cpu_addr  = 16'h0000;
        bus_if.cpu_wdata = 16'h0000;

        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_allocate();
        test_back_to_back();
        test_reset_mid_txn();
        test_miss_saturation();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
